// File: rtl/tt_loopback_pkg.sv
// Shared types and constants for the loopback checker and the LFSR it drives patterns from.
package tt_loopback_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDisChk,
    StReset,
    StDrive,
    StSettle,
    StCompare,
    StDone
  } state_e;

  // Fibonacci feedback taps 8,6,5,4 as a mask over q[7:0].
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DIS_IDX   = 8'hFF;
  localparam int unsigned N_WALK   = 8;

endpackage

// File: rtl/tt_lfsr8.sv
// 8-bit Fibonacci LFSR: load reseeds, step shifts left with the parity of the tapped bits.
module tt_lfsr8
  import tt_loopback_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED;
    end else if (load) begin
      q_q <= SEED;
    end else if (step) begin
      q_q <= {q_q[6:0], ^(q_q & LFSR_TAPS)};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tt_loopback_checker.sv
// Drives a user slot through disabled check, held reset and a pattern walk, and reports a verdict
// against the loopback contract (uo=ui, uio_oe=UIO_OE_EXP, enabled uio_out bits = ~ui).
module tt_loopback_checker
  import tt_loopback_pkg::*;
#(
  parameter int unsigned RST_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned N_RAND     = 32,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter logic [7:0]  UIO_OE_EXP = 8'hF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        usr_ena,
  output logic        usr_rst_n,
  output logic [7:0]  usr_ui_in,
  output logic [7:0]  usr_uio_in,
  input  logic [7:0]  usr_uo_out,
  input  logic [7:0]  usr_uio_out,
  input  logic [7:0]  usr_uio_oe,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [7:0]  first_fail_idx,
  output logic [23:0] first_fail_obs
);

  localparam logic [7:0] LastIdx = 8'(N_WALK + N_RAND - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q;
  logic [7:0]  idx_q;
  logic [7:0]  pat, lfsr_q;
  logic        go, dis_err, cmp_err, err_hit;
  logic [15:0] err_count_q, err_count_d;
  logic [7:0]  ff_idx_q;
  logic [23:0] ff_obs_q;
  logic        done_q, pass_q;

  tt_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == StReset),
    .step (state_q == StCompare && idx_q >= 8'(N_WALK)),
    .q    (lfsr_q)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything, including start in idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StDisChk;
      StDisChk:  if (cnt_q == 16'd1) state_d = StReset;
      StReset:   if (cnt_q == 16'(RST_CYC - 1)) state_d = StDrive;
      StDrive:   state_d = StSettle;
      StSettle:  if (cnt_q == 16'(SETTLE_CYC - 1)) state_d = StCompare;
      StCompare: state_d = (idx_q == LastIdx) ? StDone : StDrive;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (abort) begin
      state_d = (state_q == StIdle) ? StIdle : StDone;
    end
  end

  // Slot-facing outputs
  always_comb begin
    busy       = (state_q != StIdle);
    usr_ena    = state_q inside {StReset, StDrive, StSettle, StCompare};
    usr_rst_n  = state_q inside {StDrive, StSettle, StCompare};
    usr_ui_in  = usr_rst_n ? pat : 8'h00;
    usr_uio_in = usr_rst_n ? pat : 8'h00;
  end

  assign pat = (idx_q < 8'(N_WALK)) ? (8'h01 << idx_q[2:0]) : lfsr_q;

  always_comb begin
    go      = (state_q == StIdle) && start && !abort;
    dis_err = (state_q == StDisChk) && (cnt_q == 16'd1) && (usr_uo_out != 8'h00);
    cmp_err = (state_q == StCompare) &&
              ((usr_uo_out != pat) || (usr_uio_oe != UIO_OE_EXP) ||
               ((usr_uio_out & UIO_OE_EXP) != (~pat & UIO_OE_EXP)));
    err_hit = (dis_err || cmp_err) && !abort;
    err_count_d = err_count_q;
    if (go) begin
      err_count_d = 16'h0000;
    end else if (err_hit && err_count_q != 16'hFFFF) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      err_count_q <= '0;
      ff_idx_q    <= '0;
      ff_obs_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      cnt_q       <= (state_d != state_q || state_q == StIdle) ? 16'd0 : cnt_q + 16'd1;
      err_count_q <= err_count_d;
      if (go) begin
        idx_q <= '0;
      end else if (state_q == StCompare && state_d == StDrive) begin
        idx_q <= idx_q + 8'd1;
      end
      if (go) begin
        ff_idx_q <= '0;
        ff_obs_q <= '0;
      end else if (err_hit && err_count_q == 16'h0000) begin
        ff_idx_q <= dis_err ? DIS_IDX : idx_q;
        ff_obs_q <= {usr_uio_oe, usr_uio_out, usr_uo_out};
      end
      if (go) begin
        done_q <= 1'b0;
        pass_q <= 1'b0;
      end else if (state_d == StDone) begin
        done_q <= 1'b1;
        pass_q <= !abort && (err_count_d == 16'h0000);
      end
    end
  end

  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_obs = ff_obs_q;

endmodule

// File: tb/tb_tt_loopback_checker.sv
// Self-checking bench: a configurable faulty loopback slot plus a pattern-level verdict model.
module tb_tt_loopback_checker;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        usr_ena, usr_rst_n, busy, done, pass;
  logic [7:0]  usr_ui_in, usr_uio_in, usr_uo_out, usr_uio_out, usr_uio_oe;
  logic [15:0] err_count;
  logic [7:0]  first_fail_idx;
  logic [23:0] first_fail_obs;

  // Slot fault configuration
  logic [7:0] e_dis, e_and, e_xor, e_trig, e_oe, e_outx;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int NPat = 40;
  localparam int DoneLat = 2 + 4 + NPat * 4 + 1;

  always #5 clk = ~clk;

  tt_loopback_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .usr_ena        (usr_ena),
    .usr_rst_n      (usr_rst_n),
    .usr_ui_in      (usr_ui_in),
    .usr_uio_in     (usr_uio_in),
    .usr_uo_out     (usr_uo_out),
    .usr_uio_out    (usr_uio_out),
    .usr_uio_oe     (usr_uio_oe),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx),
    .first_fail_obs (first_fail_obs)
  );

  function automatic logic [7:0] slot_uo(input logic [7:0] ui);
    return (ui & e_and) ^ (((ui & e_trig) != 8'h00) ? e_xor : 8'h00);
  endfunction

  always_comb begin
    usr_uio_oe  = e_oe;
    usr_uio_out = ~usr_uio_in ^ e_outx;
    usr_uo_out  = usr_ena ? slot_uo(usr_ui_in) : e_dis;
  end

  // Verdict expected from the pattern list and the contract, evaluated per pattern.
  function automatic void model(output logic [15:0] err, output logic [7:0] idx,
                                output logic [23:0] obs);
    logic [7:0] p, lf, uo, uout;
    err = 0; idx = 0; obs = 0;
    if (e_dis != 8'h00) begin
      err = 1; idx = 8'hFF; obs = {e_oe, ~8'h00 ^ e_outx, e_dis};
    end
    lf = 8'hA5;
    for (int i = 0; i < NPat; i++) begin
      if (i < 8) begin
        p = 8'(1 << i);
      end else begin
        p  = lf;
        lf = {lf[6:0], 1'($countones(lf & 8'hB8) % 2)};
      end
      uo   = slot_uo(p);
      uout = ~p ^ e_outx;
      if (uo != p || e_oe != 8'hF0 || (uout & 8'hF0) != (~p & 8'hF0)) begin
        if (err == 0) begin
          idx = 8'(i); obs = {e_oe, uout, uo};
        end
        err++;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_env(input logic [7:0] dis, input logic [7:0] andm, input logic [7:0] xorm,
                         input logic [7:0] trig, input logic [7:0] oe, input logic [7:0] outx);
    e_dis = dis; e_and = andm; e_xor = xorm; e_trig = trig; e_oe = oe; e_outx = outx;
  endtask

  // Pulse start; on return we are at the negedge of cycle 1 after the start edge.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [15:0] xerr, input logic [7:0] xidx,
                           input logic [23:0] xobs, input logic xpass);
    int lat;
    pulse_start();
    lat = 1;
    while (!done && lat < 1000) begin
      @(negedge clk); lat++;
    end
    check({tag, " latency"}, lat, DoneLat);
    check({tag, " done"}, done, 1'b1);
    check({tag, " ena_in_done"}, usr_ena, 1'b0);
    check({tag, " pass"}, pass, xpass);
    check({tag, " err_count"}, err_count, xerr);
    check({tag, " first_idx"}, first_fail_idx, xidx);
    check({tag, " first_obs"}, first_fail_obs, xobs);
    @(negedge clk);
    check({tag, " idle_busy"}, busy, 1'b0);
    check({tag, " sticky_done"}, done, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  dis, andm, oe, outx;
    bit          use_model;
    logic [15:0] err;
    logic [7:0]  idx;
    logic [23:0] obs;
    logic        pass;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] m_err;
    logic [7:0]  m_idx;
    logic [23:0] m_obs;

    vecs[0] = '{8'h00, 8'hFF, 8'hF0, 8'h00, 1'b0, 16'd0,  8'h00, 24'h000000, 1'b1};
    vecs[1] = '{8'h00, 8'hF7, 8'hF0, 8'h00, 1'b1, 16'd0,  8'h03, 24'hF0F700, 1'b0};
    vecs[2] = '{8'h55, 8'hFF, 8'hF0, 8'h00, 1'b0, 16'd1,  8'hFF, 24'hF0FF55, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 16'd40, 8'h00, 24'hFFFE01, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 8'hF0, 8'h0F, 1'b0, 16'd0,  8'h00, 24'h000000, 1'b1};

    set_env(8'h00, 8'hFF, 8'h00, 8'h00, 8'hF0, 8'h00);
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    #1;
    check("rst ena", usr_ena, 1'b0);
    check("rst rst_n", usr_rst_n, 1'b0);
    check("rst ui", {usr_ui_in, usr_uio_in}, 16'h0000);
    check("rst status", {busy, done, pass}, 3'b000);
    check("rst err", err_count, 16'h0000);
    check("rst first", {first_fail_idx, first_fail_obs}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Table-driven fault scenarios
    for (int i = 0; i < 5; i++) begin
      set_env(vecs[i].dis, vecs[i].andm, 8'h00, 8'h00, vecs[i].oe, vecs[i].outx);
      model(m_err, m_idx, m_obs);
      if (vecs[i].use_model) begin
        check($sformatf("vec%0d model_nonzero", i), 32'(m_err > 1), 32'd1);
        run_check($sformatf("vec%0d", i), m_err, vecs[i].idx, vecs[i].obs, vecs[i].pass);
      end else begin
        run_check($sformatf("vec%0d", i), vecs[i].err, vecs[i].idx, vecs[i].obs, vecs[i].pass);
      end
    end

    // start together with abort in idle does nothing
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("idle abort busy", busy, 1'b0);

    // Abort at the third COMPARE (cycle 18); a start while busy is ignored
    set_env(8'h00, 8'hFF, 8'h00, 8'h00, 8'hF0, 8'h00);
    pulse_start();
    repeat (11) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort pre ui", usr_ui_in, 8'h04);
    check("abort pre rst_n", usr_rst_n, 1'b1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort done", done, 1'b1);
    check("abort pass", pass, 1'b0);
    check("abort ena", usr_ena, 1'b0);
    @(negedge clk);
    check("abort idle", busy, 1'b0);
    run_check("after_abort", 16'd0, 8'h00, 24'h0, 1'b1);

    // Async reset during SETTLE of pattern 2 (cycle 16), two errors already counted
    set_env(8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00);
    pulse_start();
    repeat (15) @(negedge clk);
    check("pre_rst err", err_count, 16'd2);
    check("pre_rst ena", usr_ena, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst ena", usr_ena, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst err", err_count, 16'd0);
    check("midrst rst_n", usr_rst_n, 1'b0);
    @(negedge clk); rst = 1'b0;
    set_env(8'h00, 8'hFF, 8'h00, 8'h00, 8'hF0, 8'h00);
    run_check("after_rst", 16'd0, 8'h00, 24'h0, 1'b1);

    // Randomized slot faults against the model
    for (int r = 0; r < 8; r++) begin
      set_env(($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'h00,
              ($urandom_range(2) == 0) ? ~(8'h01 << $urandom_range(7)) : 8'hFF,
              8'($urandom_range(255)),
              ($urandom_range(1) == 0) ? 8'h00 : 8'(1 << $urandom_range(7)),
              ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'hF0,
              ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(15)));
      model(m_err, m_idx, m_obs);
      run_check($sformatf("rand%0d", r), m_err, m_idx, m_obs, m_err == 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
